// File: rtl/sc_backg_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sc_backg_reader
//  Description : Parallel-in / serial-out reader for one background row word.
//                A low start request in IDLE captures the row word and its
//                bit order. Each captured bit is then presented for TICK_DIV
//                clocks, together with its position in the original word.
//                A one-cycle valid strobe marks the last cycle of each bit
//                period.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATAWIDTH  row word width / bits emitted per frame (>= 2)
//    TICK_DIV   clock cycles per emitted bit (>= 1)
//  Ports
//    SC_BackgReader_CLOCK_50      in   system clock, rising edge
//    SC_BackgReader_RESET_InLow   in   asynchronous active-low reset
//    SC_BackgReader_start_InLow   in   active-low frame request (IDLE only)
//    SC_BackgReader_dir_In        in   0 = MSB first, 1 = LSB first
//    SC_BackgReader_data_InBUS    in   row word, captured on accepted start
//    SC_BackgReader_bit_Out       out  current serial bit
//    SC_BackgReader_bitvalid_Out  out  strobe, last cycle of each bit period
//    SC_BackgReader_index_OutBUS  out  position of bit_Out in original word
//    SC_BackgReader_busy_Out      out  high while shifting and in DONE
//    SC_BackgReader_done_Out      out  one-cycle pulse after the last bit
// ============================================================================
module sc_backg_reader #(
  parameter int DATAWIDTH = 8,
  parameter int TICK_DIV  = 4
) (
  input  logic                         SC_BackgReader_CLOCK_50,
  input  logic                         SC_BackgReader_RESET_InLow,
  input  logic                         SC_BackgReader_start_InLow,
  input  logic                         SC_BackgReader_dir_In,
  input  logic [DATAWIDTH-1:0]         SC_BackgReader_data_InBUS,
  output logic                         SC_BackgReader_bit_Out,
  output logic                         SC_BackgReader_bitvalid_Out,
  output logic [$clog2(DATAWIDTH)-1:0] SC_BackgReader_index_OutBUS,
  output logic                         SC_BackgReader_busy_Out,
  output logic                         SC_BackgReader_done_Out
);

  localparam int c_IW = $clog2(DATAWIDTH);
  // One extra bit so the bit counter can never wrap inside a frame.
  localparam int c_BW = c_IW + 1;
  // Keep the tick counter at least one bit wide when TICK_DIV == 1.
  localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [DATAWIDTH-1:0]   r_shadow;
  logic                   r_dir;
  logic [c_BW-1:0]        r_bitcnt;
  logic [c_TW-1:0]        r_tickcnt;

  logic                   r_bit;
  logic                   r_bitvalid;
  logic [c_IW-1:0]        r_index;
  logic                   r_busy;
  logic                   r_done;

  state_t                 w_state_nxt;
  logic [DATAWIDTH-1:0]   w_shadow_nxt;
  logic                   w_dir_nxt;
  logic [c_BW-1:0]        w_bitcnt_nxt;
  logic [c_TW-1:0]        w_tickcnt_nxt;

  logic                   w_bit_nxt;
  logic                   w_bitvalid_nxt;
  logic [c_BW-1:0]        w_index_full;
  logic [c_IW-1:0]        w_index_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge SC_BackgReader_CLOCK_50 or negedge SC_BackgReader_RESET_InLow) begin
    if (!SC_BackgReader_RESET_InLow) begin
      r_state    <= ST_IDLE;
      r_shadow   <= '0;
      r_dir      <= 1'b0;
      r_bitcnt   <= '0;
      r_tickcnt  <= '0;
      r_bit      <= 1'b0;
      r_bitvalid <= 1'b0;
      r_index    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shadow   <= w_shadow_nxt;
      r_dir      <= w_dir_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_tickcnt  <= w_tickcnt_nxt;
      r_bit      <= w_bit_nxt;
      r_bitvalid <= w_bitvalid_nxt;
      r_index    <= w_index_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are decoded from the next
  // state/counter values so the output flops line up with the cycle in which
  // that state is current.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_shadow_nxt   = r_shadow;
    w_dir_nxt      = r_dir;
    w_bitcnt_nxt   = r_bitcnt;
    w_tickcnt_nxt  = r_tickcnt;
    w_bit_nxt      = 1'b0;
    w_bitvalid_nxt = 1'b0;
    w_index_full   = '0;
    w_index_nxt    = '0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (!SC_BackgReader_start_InLow) begin
          w_shadow_nxt  = SC_BackgReader_data_InBUS;
          w_dir_nxt     = SC_BackgReader_dir_In;
          w_bitcnt_nxt  = '0;
          w_tickcnt_nxt = '0;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_tickcnt == c_TICK_LAST) begin
          // End of bit period: move the next bit to the emitting end.
          w_shadow_nxt  = r_dir ? {1'b0, r_shadow[DATAWIDTH-1:1]}
                                : {r_shadow[DATAWIDTH-2:0], 1'b0};
          w_tickcnt_nxt = '0;
          w_bitcnt_nxt  = r_bitcnt + 1'b1;
          if (r_bitcnt == c_BIT_LAST) begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_tickcnt_nxt = r_tickcnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_state_nxt == ST_SHIFT) begin
      w_bit_nxt      = w_dir_nxt ? w_shadow_nxt[0] : w_shadow_nxt[DATAWIDTH-1];
      w_index_full   = w_dir_nxt ? w_bitcnt_nxt : (c_BIT_LAST - w_bitcnt_nxt);
      w_index_nxt    = w_index_full[c_IW-1:0];
      w_bitvalid_nxt = (w_tickcnt_nxt == c_TICK_LAST);
      w_busy_nxt     = 1'b1;
    end else if (w_state_nxt == ST_DONE) begin
      w_busy_nxt     = 1'b1;
      w_done_nxt     = 1'b1;
    end
  end

  assign SC_BackgReader_bit_Out      = r_bit;
  assign SC_BackgReader_bitvalid_Out = r_bitvalid;
  assign SC_BackgReader_index_OutBUS = r_index;
  assign SC_BackgReader_busy_Out     = r_busy;
  assign SC_BackgReader_done_Out     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sc_backg_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_backg_reader
//  Description : Directed self-checking bench for sc_backg_reader. One
//                instance uses TICK_DIV=4, a second uses TICK_DIV=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_backg_reader;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start4, dir4;
  logic [7:0] data4;
  logic       bit4, valid4, busy4, done4;
  logic [2:0] idx4;

  logic       start1, dir1;
  logic [7:0] data1;
  logic       bit1, valid1, busy1, done1;
  logic [2:0] idx1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sc_backg_reader #(.DATAWIDTH(8), .TICK_DIV(4)) u_dut4 (
    .SC_BackgReader_CLOCK_50     (clk),
    .SC_BackgReader_RESET_InLow  (rst_n),
    .SC_BackgReader_start_InLow  (start4),
    .SC_BackgReader_dir_In       (dir4),
    .SC_BackgReader_data_InBUS   (data4),
    .SC_BackgReader_bit_Out      (bit4),
    .SC_BackgReader_bitvalid_Out (valid4),
    .SC_BackgReader_index_OutBUS (idx4),
    .SC_BackgReader_busy_Out     (busy4),
    .SC_BackgReader_done_Out     (done4)
  );

  sc_backg_reader #(.DATAWIDTH(8), .TICK_DIV(1)) u_dut1 (
    .SC_BackgReader_CLOCK_50     (clk),
    .SC_BackgReader_RESET_InLow  (rst_n),
    .SC_BackgReader_start_InLow  (start1),
    .SC_BackgReader_dir_In       (dir1),
    .SC_BackgReader_data_InBUS   (data1),
    .SC_BackgReader_bit_Out      (bit1),
    .SC_BackgReader_bitvalid_Out (valid1),
    .SC_BackgReader_index_OutBUS (idx1),
    .SC_BackgReader_busy_Out     (busy1),
    .SC_BackgReader_done_Out     (done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in cycle +1 of a TICK_DIV=4 frame (start accepted at the edge just
  // before). Checks cycles +1..+33 and the idle cycle +34.
  // mode 0: release start at +1
  // mode 1: release at +1, then pulse start / disturb data+dir mid-frame
  // mode 2: keep start low, switch data to 8'hC3 at +5 (back-to-back)
  task automatic run_frame4(input logic [7:0] word, input logic dr, input int mode);
    int strobes;
    int per;
    int bpos;
    strobes = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c <= 32) begin
        per  = (c - 1) / 4;
        bpos = dr ? per : 7 - per;
        chk("f4_busy",  32'(busy4),  32'd1);
        chk("f4_valid", 32'(valid4), 32'((c % 4) == 0));
        chk("f4_bit",   32'(bit4),   32'(word[bpos]));
        chk("f4_index", 32'(idx4),   32'(bpos));
        chk("f4_done",  32'(done4),  32'd0);
        if (valid4) strobes++;
      end else begin
        chk("f4_done_pulse", 32'(done4),  32'd1);
        chk("f4_done_busy",  32'(busy4),  32'd1);
        chk("f4_done_valid", 32'(valid4), 32'd0);
      end
      if (c == 1 && mode != 2) start4 = 1'b1;
      if (mode == 1 && c == 10) begin
        start4 = 1'b0;
        data4  = 8'hFF;
        dir4   = ~dr;
      end
      if (mode == 1 && c == 12) start4 = 1'b1;
      if (mode == 2 && c == 5) begin
        data4 = 8'hC3;
        dir4  = 1'b0;
      end
      tick();
    end
    chk("f4_strobe_count", 32'(strobes), 32'd8);
    chk("f4_idle_busy",    32'(busy4),   32'd0);
    chk("f4_idle_done",    32'(done4),   32'd0);
    chk("f4_idle_valid",   32'(valid4),  32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start4 = 1'b1; dir4 = 1'b0; data4 = 8'h00;
    start1 = 1'b1; dir1 = 1'b0; data1 = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_bit4",   32'(bit4),   32'd0);
    chk("rst_valid4", 32'(valid4), 32'd0);
    chk("rst_idx4",   32'(idx4),   32'd0);
    chk("rst_busy4",  32'(busy4),  32'd0);
    chk("rst_done4",  32'(done4),  32'd0);
    chk("rst_busy1",  32'(busy1),  32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy4",  32'(busy4),  32'd0);
    chk("idle_valid4", 32'(valid4), 32'd0);

    // MSB first, 8'hA5
    start4 = 1'b0; data4 = 8'hA5; dir4 = 1'b0;
    tick();
    run_frame4(8'hA5, 1'b0, 0);

    // LSB first, 8'h81
    start4 = 1'b0; data4 = 8'h81; dir4 = 1'b1;
    tick();
    run_frame4(8'h81, 1'b1, 0);

    // Start and data/dir changes during SHIFT are ignored
    start4 = 1'b0; data4 = 8'h5A; dir4 = 1'b0;
    tick();
    run_frame4(8'h5A, 1'b0, 1);
    tick();
    chk("ignore_no_restart", 32'(busy4), 32'd0);

    // Back-to-back with start held low
    start4 = 1'b0; data4 = 8'h3C; dir4 = 1'b0;
    tick();
    run_frame4(8'h3C, 1'b0, 2);
    tick();
    run_frame4(8'hC3, 1'b0, 0);

    // Asynchronous reset mid-SHIFT
    start4 = 1'b0; data4 = 8'hA5; dir4 = 1'b0;
    tick();
    start4 = 1'b1;
    repeat (9) tick();
    chk("pre_reset_busy", 32'(busy4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bit",   32'(bit4),   32'd0);
    chk("async_rst_valid", 32'(valid4), 32'd0);
    chk("async_rst_idx",   32'(idx4),   32'd0);
    chk("async_rst_busy",  32'(busy4),  32'd0);
    chk("async_rst_done",  32'(done4),  32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_busy",  32'(busy4),  32'd0);
    chk("post_rst_valid", 32'(valid4), 32'd0);
    chk("post_rst_done",  32'(done4),  32'd0);

    // TICK_DIV=1, MSB first, 8'hF0
    start1 = 1'b0; data1 = 8'hF0; dir1 = 1'b0;
    tick();
    start1 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      chk("t1_valid", 32'(valid1), 32'd1);
      chk("t1_busy",  32'(busy1),  32'd1);
      chk("t1_bit",   32'(bit1),   32'(c <= 4));
      chk("t1_index", 32'(idx1),   32'(8 - c));
      chk("t1_done",  32'(done1),  32'd0);
      tick();
    end
    chk("t1_done_pulse", 32'(done1),  32'd1);
    chk("t1_done_valid", 32'(valid1), 32'd0);
    chk("t1_done_busy",  32'(busy1),  32'd1);
    tick();
    chk("t1_idle_busy",  32'(busy1),  32'd0);
    chk("t1_idle_done",  32'(done1),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
